// File: rtl/decode_buffer.sv
// decode_buffer: elastic valid/ready FIFO between fetch and decode.
// It holds {pc, instr, branch_predicted_taken} tuples and has a
// single-cycle flush and an almost-full flag for early fetch throttling.
module decode_buffer #(
  parameter  int PC_WIDTH    = 64,
  parameter  int INSTR_WIDTH = 64,
  parameter  int DEPTH       = 4,
  parameter  int AFULL_LEVEL = DEPTH - 1,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_in,
  input  logic                   in_valid_in,
  output logic                   in_ready_out,
  input  logic [PC_WIDTH-1:0]    pc_in,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  input  logic                   branch_predicted_taken_in,
  output logic                   out_valid_out,
  input  logic                   out_ready_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   branch_predicted_taken_out,
  output logic [CW-1:0]          count_out,
  output logic                   empty_out,
  output logic                   full_out,
  output logic                   almost_full_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = PC_WIDTH + INSTR_WIDTH + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AFULL = CW'(AFULL_LEVEL);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push, pop;

  // Flags come only from the registered count, so ready never depends on out_ready_in.
  assign empty_out       = (count_q == '0);
  assign full_out        = (count_q == CNT_FULL);
  assign almost_full_out = (count_q >= CNT_AFULL);
  assign count_out       = count_q;
  assign in_ready_out    = !full_out;
  assign out_valid_out   = !empty_out;

  assign {pc_out, instr_out, branch_predicted_taken_out} = mem_q[head_q];

  assign push = in_valid_in && in_ready_out;
  assign pop  = out_valid_out && out_ready_in;

  // Next-state: pointer/count update, tail write; flush drops everything but keeps storage.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = {pc_in, instr_in, branch_predicted_taken_in};
        tail_d        = tail_q + PTR_ONE;
      end
      if (pop) begin
        head_d = head_q + PTR_ONE;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_ONE;
      end else if (pop && !push) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  // State registers; reset outranks flush and additionally zeroes the storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: a queue-based reference model with a driver that records
// expected tuples and a negedge monitor that checks flags and popped data.
module tb_decode_buffer;

  localparam int PCW   = 64;
  localparam int IW    = 64;
  localparam int DEPTH = 4;
  localparam int AFL   = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
    logic           bp;
  } tuple_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           flush_in = 1'b0;
  logic           in_valid_in = 1'b0;
  logic           in_ready_out;
  logic [PCW-1:0] pc_in = '0;
  logic [IW-1:0]  instr_in = '0;
  logic           branch_predicted_taken_in = 1'b0;
  logic           out_valid_out;
  logic           out_ready_in = 1'b0;
  logic [PCW-1:0] pc_out;
  logic [IW-1:0]  instr_out;
  logic           branch_predicted_taken_out;
  logic [CW-1:0]  count_out;
  logic           empty_out;
  logic           full_out;
  logic           almost_full_out;

  decode_buffer #(
    .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .DEPTH(DEPTH), .AFULL_LEVEL(AFL)
  ) dut (
    .clk(clk), .reset(reset), .flush_in(flush_in),
    .in_valid_in(in_valid_in), .in_ready_out(in_ready_out),
    .pc_in(pc_in), .instr_in(instr_in),
    .branch_predicted_taken_in(branch_predicted_taken_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .pc_out(pc_out), .instr_out(instr_out),
    .branch_predicted_taken_out(branch_predicted_taken_out),
    .count_out(count_out), .empty_out(empty_out), .full_out(full_out),
    .almost_full_out(almost_full_out)
  );

  always #5 clk = ~clk;

  tuple_t exp_q[$];
  int     exp_cnt   = 0;
  bit     exp_zero  = 1'b0;
  bit     last_rst  = 1'b0;
  bit     mon_en    = 1'b0;
  int     n_chk     = 0;
  int     n_fail    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: checks state left by the previous edge and scores any pop about to happen.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count",       64'(count_out),       64'(exp_cnt));
      chk("empty",       64'(empty_out),       64'(exp_cnt == 0));
      chk("full",        64'(full_out),        64'(exp_cnt == DEPTH));
      chk("almost_full", 64'(almost_full_out), 64'(exp_cnt >= AFL));
      chk("in_ready",    64'(in_ready_out),    64'(exp_cnt < DEPTH));
      chk("out_valid",   64'(out_valid_out),   64'(exp_cnt != 0));
      if (exp_zero) begin
        chk("rst_pc",    pc_out,    64'd0);
        chk("rst_instr", instr_out, 64'd0);
        chk("rst_bp",    64'(branch_predicted_taken_out), 64'd0);
      end
      if (out_valid_out && out_ready_in && !flush_in && !reset) begin
        if (exp_cnt == 0 || exp_q.size() == 0) begin
          chk("pop_unexpected", 64'(out_valid_out), 64'd0);
        end else begin
          tuple_t t;
          t = exp_q.pop_front();
          chk("pop_pc",    pc_out,    t.pc);
          chk("pop_instr", instr_out, t.instr);
          chk("pop_bp",    64'(branch_predicted_taken_out), 64'(t.bp));
        end
      end
    end
  end

  // One cycle of stimulus; the model queue is updated with what the edge should do.
  task automatic cyc(input bit v, input logic [PCW-1:0] pc, input bit bp,
                     input bit rdy, input bit fl, input bit rs);
    tuple_t t;
    @(posedge clk);
    #2;
    exp_cnt  = exp_q.size();
    exp_zero = last_rst;
    last_rst = rs;
    t.pc    = pc;
    t.instr = {$urandom, $urandom};
    t.bp    = bp;
    in_valid_in               = v;
    pc_in                     = t.pc;
    instr_in                  = t.instr;
    branch_predicted_taken_in = t.bp;
    out_ready_in              = rdy;
    flush_in                  = fl;
    reset                     = rs;
    if (rs || fl) exp_q.delete();
    else if (v && exp_cnt < DEPTH) exp_q.push_back(t);
  endtask

  initial begin
    logic [PCW-1:0] p;
    // reset for two cycles, then idle
    cyc(0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // fill with decode stalled, attempt a fifth push, then drain
    for (int i = 0; i < 5; i++) cyc(1, 64'h100 + 64'(4 * i), i[0], 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0, 0);
    // streaming 20 tuples with concurrent pops
    for (int i = 0; i < 20; i++) cyc(1, 64'h1000 + 64'(4 * i), 1'($urandom), 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
    // push+pop at count 0, then at count 4
    cyc(1, 64'h300, 1, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 64'h400 + 64'(4 * i), 0, 0, 0, 0);
    cyc(1, 64'h4F0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // flush at count 3 with a push in the flush cycle
    cyc(1, 64'h500, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 64'h600 + 64'(4 * i), 1, 0, 0, 0);
    cyc(1, 64'h6FF, 0, 1, 1, 0);
    cyc(1, 64'h200, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    // reset together with flush at count 2
    cyc(1, 64'h700, 1, 0, 0, 0);
    cyc(1, 64'h704, 1, 0, 0, 0);
    cyc(1, 64'h708, 1, 1, 1, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      p = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 3) != 0), p, 1'($urandom),
          1'($urandom_range(0, 2) != 0), ($urandom_range(0, 23) == 0),
          ($urandom_range(0, 79) == 0));
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Parametrised elastic instruction buffer between fetch and decode, replacing the single global-stall handoff with a valid/ready FIFO. Fetch pushes `{pc, instr, branch_predicted_taken}` tuples. Decode pops them in order. A flush drops every buffered entry in one cycle. Depth, PC width and instruction width are parameters, and an almost-full flag lets fetch throttle early.

## Interface

Parameters:
- `PC_WIDTH`, 64, width of program counter field
- `INSTR_WIDTH`, 64, width of fetched instruction word
- `DEPTH`, 4, number of entries; power of two, ≥ 2
- `AFULL_LEVEL`, DEPTH-1, count at or above which `almost_full_out` asserts; 1 ≤ AFULL_LEVEL ≤ DEPTH

Ports (CW = $clog2(DEPTH+1)):
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `flush_in`  in  1  discard all buffered entries (branch mispredict / trap)
- `in_valid_in`  in  1  fetch presents a tuple
- `in_ready_out`  out  1  buffer can accept a tuple this cycle
- `pc_in`  in  PC_WIDTH  fetched PC
- `instr_in`  in  INSTR_WIDTH  fetched instruction
- `branch_predicted_taken_in`  in  1  fetch prediction bit
- `out_valid_out`  out  1  head entry is valid
- `out_ready_in`  in  1  decode accepts head this cycle (decode drives `!stall`)
- `pc_out`  out  PC_WIDTH  head PC
- `instr_out`  out  INSTR_WIDTH  head instruction
- `branch_predicted_taken_out`  out  1  head prediction bit
- `count_out`  out  CW  number of valid entries
- `empty_out`  out  1  count == 0
- `full_out`  out  1  count == DEPTH
- `almost_full_out`  out  1  count ≥ AFULL_LEVEL

## Operation

State:
- Circular storage of DEPTH entries.
- Head and tail pointers, log2(DEPTH) bits each, wrap naturally modulo DEPTH.
- Registered count.

Handshake:
- Push = `in_valid_in && in_ready_out`. Writes the tuple at the tail and advances the tail.
- Pop = `out_valid_out && out_ready_in`. Advances the head.

Derived outputs:
- `in_ready_out = !full_out`. It depends only on registered count, never on `out_ready_in`, so there is no combinational in→out path.
- `out_valid_out = !empty_out`.
- `pc_out`, `instr_out` and `branch_predicted_taken_out` are read from storage at the head. Their value is meaningful only while `out_valid_out` is high.

Count update:
- Push only: +1.
- Pop only: −1.
- Both or neither: unchanged.

Simultaneous push and pop:
- When neither full nor empty, both occur and count holds.
- When empty, only the push can occur (pop needs valid). The entry is not bypassed.
- When full, only the pop can occur (push needs ready).

Flush (`flush_in` high at an edge):
- Head, tail and count go to 0.
- Any push or pop presented in that cycle is discarded and has no effect on state.
- Storage contents are not cleared.

Reset (`reset` high at an edge):
- Same as flush, and additionally all storage entries are cleared to 0.
- Reset has priority over flush. Reset mid-stream discards everything.

No error outputs:
- Pushes while `in_ready_out`=0 are ignored.
- Pops while `out_valid_out`=0 are ignored.

## Timing

Reset values of all outputs:
- `out_valid_out`=0
- `in_ready_out`=1
- `pc_out`=0, `instr_out`=0, `branch_predicted_taken_out`=0
- `count_out`=0
- `empty_out`=1, `full_out`=0
- `almost_full_out`=0, since AFULL_LEVEL ≥ 1

Latency and throughput:
- Push→visible latency: 1 cycle. A tuple pushed at edge N appears on the outputs with `out_valid_out`=1 in the cycle after edge N, if it is at the head.
- Sustained throughput: 1 push and 1 pop per cycle when 0 < count < DEPTH.

Flag timing:
- `full_out`, `empty_out`, `almost_full_out` and `count_out` are all functions of the registered count. They change only at edges.

Flush timing:
- The cycle after a flush edge has `out_valid_out`=0 and `in_ready_out`=1.
- A new push is accepted in that same cycle.

Wrap-around:
- The pointer after DEPTH-1 is 0.
- Ordering is preserved across the wrap.

## Test plan

- **Reset defaults:** reset 2 cycles, then idle → all outputs at the reset values above; `in_ready_out`=1.
- **Fill and drain:** DEPTH=4, `out_ready_in`=0, push pc 0x100,0x104,0x108,0x10C.
  - Count goes 1,2,3,4.
  - `almost_full_out` rises at count 3; `full_out` and `in_ready_out`=0 at count 4.
  - A fifth push is held off.
  - Raise `out_ready_in` → pops 0x100..0x10C in order; `empty_out`=1 after the 4th pop.
- **Streaming with wrap:** continuous push and pop of 20 tuples with random `branch_predicted_taken_in` → output sequence equals input sequence; count stays constant once primed; pointers wrap ≥4 times.
- **Simultaneous push and pop:**
  - At count 0: push and pop requested together → only the push takes effect; count=1 next cycle.
  - At count 4: push and pop requested together → only the pop takes effect; count=3.
- **Flush mid-stream:** count=3 and push asserted in the flush cycle → next cycle count=0, `out_valid_out`=0; the flush-cycle push is absent. A following push of pc 0x200 appears at the head 1 cycle later.
- **Reset over flush:** `reset` and `flush_in` both high with count=2 → reset values exactly, including `pc_out`=0 and `instr_out`=0.
